// File: rtl/memory_fifo_tester.sv
// Bring-up harness for the FIFO path: load Feature_Memory, copy it through a
// synchronous FIFO into Weight_Memory and expose each drained word on port_D.
module memory_fifo_tester #(
   parameter int DATA_W     = 8,
   parameter int MEM_DEPTH  = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] port_A,
   input  logic              W_en,
   input  logic              s_sig,
   input  logic              R_en,
   output logic [DATA_W-1:0] port_D,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              copy_done
);

   localparam int MEM_AW  = $clog2(MEM_DEPTH);
   localparam int FIFO_AW = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = FIFO_AW + 1;

   logic [DATA_W-1:0]  Feature_Memory [MEM_DEPTH];
   logic [DATA_W-1:0]  Weight_Memory  [MEM_DEPTH];
   logic [DATA_W-1:0]  fifo_mem       [FIFO_DEPTH];

   logic [MEM_AW-1:0]  ld_ptr_q,  ld_ptr_d;
   logic [MEM_AW-1:0]  src_idx_q, src_idx_d;
   logic [MEM_AW-1:0]  dst_idx_q, dst_idx_d;
   logic               copy_done_q, copy_done_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [DATA_W-1:0]  port_d_q, port_d_d;

   logic               push;
   logic               pop;
   logic [DATA_W-1:0]  head_word;

   // Handshake: push fires when the source has a word (s_sig, not loading,
   // copy unfinished) and the FIFO is not full; pop fires when R_en is high
   // and the FIFO is not empty. Both use the registered count, so a word
   // pushed on one edge is first poppable on the next.
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = s_sig && !W_en && !copy_done_q && !fifo_full;
   assign pop        = R_en && !fifo_empty;
   assign head_word  = fifo_mem[rd_ptr_q];

   assign port_D    = port_d_q;
   assign copy_done = copy_done_q;

   always_comb begin
      ld_ptr_d    = ld_ptr_q;
      src_idx_d   = src_idx_q;
      dst_idx_d   = dst_idx_q;
      copy_done_d = copy_done_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      port_d_d    = port_d_q;

      if (W_en) begin
         ld_ptr_d    = ld_ptr_q + 1'b1;
         src_idx_d   = '0;
         copy_done_d = 1'b0;
      end else if (push) begin
         src_idx_d = src_idx_q + 1'b1;
         if (src_idx_q == MEM_AW'(MEM_DEPTH - 1)) copy_done_d = 1'b1;
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;

      // A load re-arms the copy, so it overrides the destination advance.
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         port_d_d  = head_word;
         dst_idx_d = dst_idx_q + 1'b1;
      end
      if (W_en) dst_idx_d = '0;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_ptr_q    <= '0;
         src_idx_q   <= '0;
         dst_idx_q   <= '0;
         copy_done_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         port_d_q    <= '0;
      end else begin
         ld_ptr_q    <= ld_ptr_d;
         src_idx_q   <= src_idx_d;
         dst_idx_q   <= dst_idx_d;
         copy_done_q <= copy_done_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         port_d_q    <= port_d_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) Feature_Memory[i] <= '0;
      end else if (W_en) begin
         Feature_Memory[ld_ptr_q] <= port_A;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) Weight_Memory[i] <= '0;
      end else if (pop) begin
         Weight_Memory[dst_idx_q] <= head_word;
      end
   end

   // FIFO storage needs no reset: the pointers and count gate every read.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= Feature_Memory[src_idx_q];
   end

endmodule

// File: tb/tb_memory_fifo_tester.sv
// Directed bench for memory_fifo_tester: reset, load, stream, full stall,
// pause/resume and mid-transfer reset, all against hand-written word lists.
module tb_memory_fifo_tester;

   logic       clk;
   logic       rst;
   logic [7:0] port_A;
   logic       W_en;
   logic       s_sig;
   logic       R_en;
   logic [7:0] port_D;
   logic       fifo_full;
   logic       fifo_empty;
   logic       copy_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] list1 [16] = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                              8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};
   logic [7:0] list2 [16] = '{8'd17, 8'd34, 8'd51, 8'd68, 8'd85, 8'd102, 8'd119, 8'd136,
                              8'd153, 8'd170, 8'd187, 8'd204, 8'd221, 8'd238, 8'd255, 8'd1};

   memory_fifo_tester #(.DATA_W(8), .MEM_DEPTH(16), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .port_A     (port_A),
      .W_en       (W_en),
      .s_sig      (s_sig),
      .R_en       (R_en),
      .port_D     (port_D),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .copy_done  (copy_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_list(input logic [7:0] words [16]);
      for (int i = 0; i < 16; i++) begin
         W_en   = 1'b1;
         port_A = words[i];
         tick();
      end
      W_en   = 1'b0;
      port_A = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      checks++;
      if (port_D !== 8'd0) begin
         errors++; $display("FAIL reset_port_D got %0d want 0", port_D);
      end
      checks++;
      if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
         errors++; $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", fifo_empty, fifo_full);
      end
      checks++;
      if (copy_done !== 1'b0) begin
         errors++; $display("FAIL reset_copy_done got %0b want 0", copy_done);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut.Feature_Memory[i] !== 8'd0 || dut.Weight_Memory[i] !== 8'd0) begin
            errors++;
            $display("FAIL reset_mem[%0d] got fm=%0d wm=%0d want 0/0", i,
                     dut.Feature_Memory[i], dut.Weight_Memory[i]);
         end
      end
   endtask

   task automatic test_load();
      load_list(list1);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut.Feature_Memory[i] !== list1[i]) begin
            errors++; $display("FAIL load_fm[%0d] got %0d want %0d", i, dut.Feature_Memory[i], list1[i]);
         end
      end
      checks++;
      if (fifo_empty !== 1'b1) begin
         errors++; $display("FAIL load_no_push got empty=%0b want 1", fifo_empty);
      end
   endtask

   task automatic test_stream();
      logic [7:0] exp_d;
      s_sig = 1'b1;
      R_en  = 1'b1;
      exp_d = 8'd0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k >= 2 && k <= 17) exp_d = list1[k-2];
         checks++;
         if (port_D !== exp_d) begin
            errors++; $display("FAIL stream_port_D edge %0d got %0d want %0d", k, port_D, exp_d);
         end
         if (k == 15 || k == 16) begin
            checks++;
            if (copy_done !== (k == 16)) begin
               errors++; $display("FAIL stream_copy_done edge %0d got %0b want %0b", k, copy_done, k == 16);
            end
         end
      end
      s_sig = 1'b0;
      R_en  = 1'b0;
      checks++;
      if (fifo_empty !== 1'b1 || copy_done !== 1'b1) begin
         errors++; $display("FAIL stream_end got empty=%0b done=%0b want 1/1", fifo_empty, copy_done);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut.Weight_Memory[i] !== list1[i]) begin
            errors++; $display("FAIL stream_wm[%0d] got %0d want %0d", i, dut.Weight_Memory[i], list1[i]);
         end
      end
   endtask

   task automatic test_full_stall();
      load_list(list2);
      checks++;
      if (copy_done !== 1'b0 || dut.src_idx_q !== 4'd0) begin
         errors++; $display("FAIL rearm got done=%0b src=%0d want 0/0", copy_done, dut.src_idx_q);
      end
      s_sig = 1'b1;
      R_en  = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 7 || k == 8) begin
            checks++;
            if (fifo_full !== (k == 8)) begin
               errors++; $display("FAIL full_flag edge %0d got %0b want %0b", k, fifo_full, k == 8);
            end
         end
      end
      repeat (3) tick();
      checks++;
      if (dut.src_idx_q !== 4'd8 || fifo_full !== 1'b1) begin
         errors++; $display("FAIL full_stall got src=%0d full=%0b want 8/1", dut.src_idx_q, fifo_full);
      end
      R_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++;
         if (port_D !== list2[k-1]) begin
            errors++; $display("FAIL full_drain edge %0d got %0d want %0d", k, port_D, list2[k-1]);
         end
      end
      checks++;
      if (fifo_empty !== 1'b1 || copy_done !== 1'b1) begin
         errors++; $display("FAIL full_end got empty=%0b done=%0b want 1/1", fifo_empty, copy_done);
      end
      repeat (2) tick();
      checks++;
      if (port_D !== list2[15]) begin
         errors++; $display("FAIL hold_port_D got %0d want %0d", port_D, list2[15]);
      end
      s_sig = 1'b0;
      R_en  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut.Weight_Memory[i] !== list2[i]) begin
            errors++; $display("FAIL full_wm[%0d] got %0d want %0d", i, dut.Weight_Memory[i], list2[i]);
         end
      end
   endtask

   task automatic test_pause_resume();
      load_list(list1);
      s_sig = 1'b1;
      R_en  = 1'b1;
      repeat (5) tick();
      s_sig = 1'b0;
      repeat (3) tick();
      checks++;
      if (dut.src_idx_q !== 4'd5) begin
         errors++; $display("FAIL pause_src got %0d want 5", dut.src_idx_q);
      end
      checks++;
      if (port_D !== list1[4] || fifo_empty !== 1'b1 || copy_done !== 1'b0) begin
         errors++;
         $display("FAIL pause_state got d=%0d empty=%0b done=%0b want %0d/1/0",
                  port_D, fifo_empty, copy_done, list1[4]);
      end
      s_sig = 1'b1;
      tick();
      tick();
      checks++;
      if (port_D !== list1[5]) begin
         errors++; $display("FAIL resume_first got %0d want %0d", port_D, list1[5]);
      end
      repeat (15) tick();
      s_sig = 1'b0;
      R_en  = 1'b0;
      checks++;
      if (port_D !== list1[15] || copy_done !== 1'b1) begin
         errors++; $display("FAIL resume_end got d=%0d done=%0b want %0d/1", port_D, copy_done, list1[15]);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut.Weight_Memory[i] !== list1[i]) begin
            errors++; $display("FAIL resume_wm[%0d] got %0d want %0d", i, dut.Weight_Memory[i], list1[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      load_list(list2);
      s_sig = 1'b1;
      R_en  = 1'b1;
      repeat (6) tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (port_D !== 8'd0 || fifo_empty !== 1'b1 || copy_done !== 1'b0 || dut.src_idx_q !== 4'd0) begin
         errors++;
         $display("FAIL midrst_state got d=%0d empty=%0b done=%0b src=%0d want 0/1/0/0",
                  port_D, fifo_empty, copy_done, dut.src_idx_q);
      end
      checks++;
      if (dut.Feature_Memory[3] !== 8'd0 || dut.Weight_Memory[0] !== 8'd0) begin
         errors++;
         $display("FAIL midrst_mem got fm3=%0d wm0=%0d want 0/0", dut.Feature_Memory[3], dut.Weight_Memory[0]);
      end
      s_sig = 1'b0;
      R_en  = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      load_list(list1);
      s_sig = 1'b1;
      R_en  = 1'b1;
      repeat (20) tick();
      s_sig = 1'b0;
      R_en  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut.Weight_Memory[i] !== list1[i]) begin
            errors++; $display("FAIL midrst_wm[%0d] got %0d want %0d", i, dut.Weight_Memory[i], list1[i]);
         end
      end
   endtask

   initial begin
      rst    = 1'b0;
      port_A = '0;
      W_en   = 1'b0;
      s_sig  = 1'b0;
      R_en   = 1'b0;
      test_reset();
      test_load();
      test_stream();
      test_full_stall();
      test_pause_resume();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_fifo_tester.md
Name: memory_fifo_tester

Overview:
- Self-contained memory/FIFO test harness.
- Loads a 16-entry feature memory sequentially from an input port, then streams its contents through an internal synchronous FIFO into a 16-entry weight memory.
- Presents each word as it is drained, for checking data integrity of the FIFO path.
- Used as a bring-up/regression block for the FIFO subsystem.

Parameters:
- DATA_W, 8, data width of port_A, port_D, both memories and the FIFO.
- MEM_DEPTH, 16, entries in Feature_Memory and Weight_Memory (power of 2).
- FIFO_DEPTH, 8, internal FIFO entries (power of 2).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately while low.
- port_A  input  DATA_W  load data for Feature_Memory.
- W_en  input  1  load strobe; one word written per cycle while high.
- s_sig  input  1  transfer enable; Feature_Memory → FIFO push while high.
- R_en  input  1  drain enable; FIFO → Weight_Memory/port_D pop while high.
- port_D  output  DATA_W  last word popped from the FIFO (registered).
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- fifo_empty  output  1  FIFO holds 0 words.
- copy_done  output  1  all MEM_DEPTH words have been pushed.

Behaviour:
- Internal arrays must be named exactly Feature_Memory and Weight_Memory; benches read them hierarchically.
- Reset (rst low):
  - Feature_Memory and Weight_Memory entries = 0.
  - Load pointer, source index and destination index = 0.
  - FIFO pointers and count = 0.
  - port_D = 0, fifo_empty = 1, fifo_full = 0, copy_done = 0.
- Load:
  - On each edge with W_en=1: Feature_Memory[ld_ptr] <= port_A; ld_ptr increments, wrapping MEM_DEPTH-1 → 0.
  - W_en=1 also clears src_idx, dst_idx and copy_done, re-arming a new copy.
  - While W_en=1, no pushes occur; W_en has priority over s_sig.
- Transfer:
  - On each edge with s_sig=1, W_en=0, copy_done=0 and FIFO not full: push Feature_Memory[src_idx]; src_idx increments.
  - When the push of index MEM_DEPTH-1 occurs, copy_done <= 1 and src_idx wraps to 0.
  - s_sig=0 pauses the transfer; the position is kept.
  - Full FIFO stalls pushes without loss.
- Drain:
  - On each edge with R_en=1 and FIFO not empty: pop the head word; port_D <= word; Weight_Memory[dst_idx] <= word; dst_idx increments (wraps).
  - port_D holds its value when no pop occurs.
  - Pop while empty is ignored: no pointer change, no write.
- FIFO:
  - Synchronous, single clock; no fall-through.
  - A word pushed at edge N is first poppable at edge N+1.
  - Latency from s_sig rising (FIFO empty, R_en=1) to first port_D update: 2 edges.
  - Simultaneous push and pop in one cycle are both performed; count unchanged.
  - fifo_full/fifo_empty are derived from the registered count; they are valid after each edge.
  - Push into full is blocked internally, so overflow is impossible.
- Ordering: words appear on port_D strictly in Feature_Memory index order 0..MEM_DEPTH-1.
- Reset asserted mid-operation aborts everything immediately; all state returns to reset values.

Test Plan:
- Reset with rst=0 for 10 cycles, then release → port_D=0, fifo_empty=1, copy_done=0, both memories all 0.
- Load 16 words with W_en=1: 4,14,24,42,141,243,41,134,204,124,104,24,34,74,84,95 → Feature_Memory[0..15] equals that list.
- After the load, set s_sig=1 and R_en=1 together for 20 cycles:
  - port_D shows the 16 words in order, first update 2 edges after s_sig rises.
  - copy_done=1; Weight_Memory[0..15] equals Feature_Memory.
- Set s_sig=1 with R_en=0:
  - fifo_full=1 after 8 pushes; src_idx stalls at 8.
  - Then raise R_en: the remaining 8 words flow with no loss or duplication.
- Drop s_sig after 5 cycles and re-raise it later → the transfer resumes at index 5; the final Weight_Memory is still correct.
- Assert rst mid-transfer → immediate clear; a new load plus transfer then completes correctly.
